// File: rtl/fwd_ctrl.sv
// Forwarding-select and load-use stall controller for a classic 5-stage pipeline.
// Tracks operand/destination tags from EX through WB and drives the EX operand mux selects.
module fwd_ctrl #(
    parameter int reg_addr_size = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [reg_addr_size-1:0] id_rs,
    input  logic [reg_addr_size-1:0] id_rt,
    input  logic                     id_uses_rt,
    input  logic [reg_addr_size-1:0] id_dst,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    output logic [1:0]               ex_sel_a,
    output logic [1:0]               ex_sel_b,
    output logic                     stall,
    output logic [15:0]              stall_cnt
);

    logic [reg_addr_size-1:0] r_ex_rs;
    logic [reg_addr_size-1:0] r_ex_rt;
    logic [reg_addr_size-1:0] r_ex_dst;
    logic                     r_ex_wr;
    logic                     r_ex_ld;
    logic [reg_addr_size-1:0] r_mem_dst;
    logic                     r_mem_wr;
    logic [reg_addr_size-1:0] r_wb_dst;
    logic                     r_wb_wr;
    logic [15:0]              r_stall_cnt;

    logic w_stall;
    logic w_bubble;
    logic w_mem_fwd_a;
    logic w_mem_fwd_b;
    logic w_wb_fwd_a;
    logic w_wb_fwd_b;

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    assign w_stall = id_valid && r_ex_ld && r_ex_wr && (r_ex_dst != '0) &&
                     ((r_ex_dst == id_rs) || (id_uses_rt && (r_ex_dst == id_rt)));
    assign w_bubble = w_stall || flush || !id_valid;

    assign w_mem_fwd_a = r_mem_wr && (r_mem_dst != '0) && (r_mem_dst == r_ex_rs);
    assign w_mem_fwd_b = r_mem_wr && (r_mem_dst != '0) && (r_mem_dst == r_ex_rt);
    assign w_wb_fwd_a  = r_wb_wr  && (r_wb_dst  != '0) && (r_wb_dst  == r_ex_rs);
    assign w_wb_fwd_b  = r_wb_wr  && (r_wb_dst  != '0) && (r_wb_dst  == r_ex_rt);

    // The MEM copy is newer than the WB copy, so it wins when both match.
    always_comb begin
        ex_sel_a = 2'b00;
        ex_sel_b = 2'b00;
        if (w_mem_fwd_a)     ex_sel_a = 2'b10;
        else if (w_wb_fwd_a) ex_sel_a = 2'b01;
        if (w_mem_fwd_b)     ex_sel_b = 2'b10;
        else if (w_wb_fwd_b) ex_sel_b = 2'b01;
    end

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_dst    <= '0;
            r_ex_wr     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_mem_dst   <= '0;
            r_mem_wr    <= 1'b0;
            r_wb_dst    <= '0;
            r_wb_wr     <= 1'b0;
            r_stall_cnt <= '0;
        end else if (en) begin
            r_wb_dst  <= r_mem_dst;
            r_wb_wr   <= r_mem_wr;
            r_mem_dst <= r_ex_dst;
            r_mem_wr  <= r_ex_wr;
            if (w_bubble) begin
                r_ex_rs  <= '0;
                r_ex_rt  <= '0;
                r_ex_dst <= '0;
                r_ex_wr  <= 1'b0;
                r_ex_ld  <= 1'b0;
            end else begin
                r_ex_rs  <= id_rs;
                r_ex_rt  <= id_rt;
                r_ex_dst <= id_dst;
                r_ex_wr  <= id_reg_write;
                r_ex_ld  <= id_mem_read;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: an instruction-history model is checked every cycle,
// and literal expectations at key points pin that model to the intended behaviour.
module tb_fwd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  id_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic [1:0]  ex_sel_a;
    logic [1:0]  ex_sel_b;
    logic        stall;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fwd_ctrl #(.reg_addr_size(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_dst      (id_dst),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .ex_sel_a    (ex_sel_a),
        .ex_sel_b    (ex_sel_b),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the last three instructions that left ID, newest first (EX, MEM, WB).
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } ins_t;

    ins_t hist [3];
    int   m_cnt;

    function automatic logic m_stall();
        return id_valid && hist[0].ld && hist[0].wr && hist[0].dst != 5'd0 &&
               (hist[0].dst == id_rs || (id_uses_rt && hist[0].dst == id_rt));
    endfunction

    // Nearest older producer of src wins; distance 1 -> 10, distance 2 -> 01.
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        for (int d = 1; d <= 2; d++) begin
            if (hist[d].wr && hist[d].dst != 5'd0 && hist[d].dst == src)
                return (d == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
            m_cnt   <= 0;
        end else if (en) begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            if (m_stall() || flush || !id_valid)
                hist[0] <= '0;
            else
                hist[0] <= '{rs: id_rs, rt: id_rt, dst: id_dst, wr: id_reg_write, ld: id_mem_read};
            if (m_stall() && m_cnt < 65535)
                m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] dst, input logic wr,
                         input logic ld);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        id_dst       = dst;
        id_reg_write = wr;
        id_mem_read  = ld;
        $display("t=%0t ID v=%0d rs=%0d rt=%0d urt=%0d dst=%0d wr=%0d ld=%0d en=%0d flush=%0d",
                 $time, v, rs, rt, urt, dst, wr, ld, en, flush);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        en    = 1'b1;
        flush = 1'b0;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        fork
            forever begin
                @(negedge clk);
                chk("model_sel_a", {14'd0, ex_sel_a}, {14'd0, m_fwd(hist[0].rs)});
                chk("model_sel_b", {14'd0, ex_sel_b}, {14'd0, m_fwd(hist[0].rt)});
                chk("model_stall", {15'd0, stall}, {15'd0, m_stall()});
                chk("model_stall_cnt", stall_cnt, m_cnt[15:0]);
            end
        join_none

        #2 rst_n = 1'b0;
        #1;
        chk("reset_sel_a", {14'd0, ex_sel_a}, 16'd0);
        chk("reset_sel_b", {14'd0, ex_sel_b}, 16'd0);
        chk("reset_stall", {15'd0, stall}, 16'd0);
        chk("reset_cnt", stall_cnt, 16'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Back-to-back ALU: add r3 ; sub r5,r3,r4
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0); step();
        chk("b2b_sel_a", {14'd0, ex_sel_a}, 16'b10);
        chk("b2b_sel_b", {14'd0, ex_sel_b}, 16'b00);
        nops(3);

        // Two producers of r3: the newer (MEM) copy wins
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
        drive(1'b1, 5'd6, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0); step();
        drive(1'b1, 5'd3, 5'd8, 1'b1, 5'd12, 1'b1, 1'b0); step();
        chk("prio_sel_a", {14'd0, ex_sel_a}, 16'b10);
        chk("prio_sel_b", {14'd0, ex_sel_b}, 16'b00);
        nops(3);

        // Distance two: add r3 ; add r9 ; use r3 on both operands
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
        drive(1'b1, 5'd10, 5'd11, 1'b1, 5'd9, 1'b1, 1'b0); step();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd12, 1'b1, 1'b0); step();
        chk("dist2_sel_a", {14'd0, ex_sel_a}, 16'b01);
        chk("dist2_sel_b", {14'd0, ex_sel_b}, 16'b01);
        nops(1);
        chk("dist3_sel_a", {14'd0, ex_sel_a}, 16'b00);
        nops(3);

        // Load-use: lw r7 ; add r2,r7,r1 (consumer held in ID for the stall cycle)
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
        drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        #1 chk("lu_stall_on", {15'd0, stall}, 16'd1);
        step();
        chk("lu_stall_off", {15'd0, stall}, 16'd0);
        chk("lu_cnt", stall_cnt, 16'd1);
        step();
        chk("lu_sel_a", {14'd0, ex_sel_a}, 16'b01);
        chk("lu_sel_b", {14'd0, ex_sel_b}, 16'b00);
        nops(3);

        // Load followed by an independent instruction
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
        drive(1'b1, 5'd8, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
        #1 chk("indep_stall", {15'd0, stall}, 16'd0);
        step();
        chk("indep_cnt", stall_cnt, 16'd1);
        nops(3);

        // Register 0: load writing r0, consumer reads r0 twice
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); step();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        #1 chk("r0_stall", {15'd0, stall}, 16'd0);
        step();
        chk("r0_sel_a", {14'd0, ex_sel_a}, 16'b00);
        chk("r0_sel_b", {14'd0, ex_sel_b}, 16'b00);
        nops(3);

        // Freeze inside a forwarding window
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
        drive(1'b1, 5'd3, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0); step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_sel_a", {14'd0, ex_sel_a}, 16'b10);
            chk("frz_cnt", stall_cnt, 16'd1);
        end
        en = 1'b1;
        nops(3);

        // Flush with a load-use in ID
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
        flush = 1'b1;
        drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd2, 1'b1, 1'b0);
        #1 chk("fl_stall", {15'd0, stall}, 16'd1);
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("fl_sel_a", {14'd0, ex_sel_a}, 16'b00);
        chk("fl_sel_b", {14'd0, ex_sel_b}, 16'b00);
        chk("fl_cnt", stall_cnt, 16'd2);
        nops(3);

        // Asynchronous reset mid-cycle during a stall
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
        drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        #1 chk("ar_pre_stall", {15'd0, stall}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_stall", {15'd0, stall}, 16'd0);
        chk("ar_sel_a", {14'd0, ex_sel_a}, 16'b00);
        chk("ar_sel_b", {14'd0, ex_sel_b}, 16'b00);
        chk("ar_cnt", stall_cnt, 16'd0);
        step();
        step();
        chk("ar_hold_stall", {15'd0, stall}, 16'd0);
        chk("ar_hold_cnt", stall_cnt, 16'd0);
        #2 rst_n = 1'b1;
        nops(3);
        chk("ar_post_cnt", stall_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
